// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencing controller: PC mux
// encoding, controller states, and the redirect record.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package fetch_pkg;

    localparam int INST_ADDR_WIDTH = `INST_ADDR_WIDTH;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        SB       = 2'd1,
        UJ       = 2'd2,
        JALR     = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2
    } fctrl_state_e;

    typedef struct packed {
        pc_sel_e                    sel;
        logic [INST_ADDR_WIDTH-1:0] addr;
    } redirect_t;

    // Older pipeline stages win: execute (JALR, SB) beats decode (UJ).
    function automatic logic [1:0] pc_sel_prio(input pc_sel_e sel);
        case (sel)
            JALR:    return 2'd3;
            SB:      return 2'd2;
            UJ:      return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_credit_cnt.sv
// Fetch-buffer credit counter: one credit per free group slot, refilled on
// a buffer flush.
module fetch_credit_cnt
    import fetch_pkg::*;
#(
    parameter int FB_DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic flush,
    output logic zero,
    output logic full
);

    localparam logic [3:0] DEPTH_C = 4'(FB_DEPTH);

    logic [3:0] credits;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            credits <= DEPTH_C;
        end else if (push && !pop) begin
            credits <= credits - 4'd1;
        end else if (pop && !push) begin
            credits <= credits + 4'd1;
        end
    end

    assign zero = (credits == 4'd0);
    assign full = (credits == DEPTH_C);

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !flush && zero));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && !push && !flush && full));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: arbitrates redirects, holds them across
// stalls, inserts post-redirect bubbles and gates pushes on buffer credits.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W       = INST_ADDR_WIDTH,
    parameter int FB_DEPTH     = 8,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jalr_valid,
    input  logic [ADDR_W-1:0] jalr_addr,
    input  logic              sb_taken,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              uj_valid,
    input  logic [ADDR_W-1:0] uj_addr,
    input  logic              backend_stall,
    input  logic              fb_pop,
    output logic [1:0]        next_pc_sel,
    output logic [ADDR_W-1:0] sb_type_addr,
    output logic [ADDR_W-1:0] uj_type_addr,
    output logic [ADDR_W-1:0] jalr_type_addr,
    output logic              ifu_stall,
    output logic              fetch_valid,
    output logic              flush_fb
);

    localparam logic [2:0] BUBBLE_LOAD = 3'(FLUSH_CYCLES);

    fctrl_state_e state, state_next;
    redirect_t    pend, pend_next, win, drive;
    logic [2:0]   cnt, cnt_next;
    logic         have_redirect, base_stall, overwrite;
    logic         cred_zero, cred_full, push;

    always_comb begin
        win = '0;
        if (jalr_valid) begin
            win.sel  = JALR;
            win.addr = jalr_addr;
        end else if (sb_taken) begin
            win.sel  = SB;
            win.addr = sb_addr;
        end else if (uj_valid) begin
            win.sel  = UJ;
            win.addr = uj_addr;
        end
    end

    assign have_redirect = jalr_valid | sb_taken | uj_valid;
    assign base_stall    = backend_stall | cred_zero;
    assign overwrite     = have_redirect && (pc_sel_prio(win.sel) > pc_sel_prio(pend.sel));

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        state_next  = state;
        pend_next   = pend;
        cnt_next    = cnt;
        drive       = '0;
        fetch_valid = 1'b0;
        flush_fb    = 1'b0;

        case (state)
            RUN, BUBBLE: begin
                if (have_redirect) begin
                    drive    = win;
                    flush_fb = 1'b1;
                    if (base_stall) begin
                        pend_next  = win;
                        state_next = HOLD;
                    end else begin
                        state_next = (FLUSH_CYCLES == 0) ? RUN : BUBBLE;
                        cnt_next   = BUBBLE_LOAD;
                    end
                end else if (state == RUN) begin
                    fetch_valid = ~base_stall;
                end else if (!base_stall) begin
                    if (cnt == 3'd1) state_next = RUN;
                    else             cnt_next   = cnt - 3'd1;
                end
            end
            HOLD: begin
                drive    = overwrite ? win : pend;
                flush_fb = overwrite;
                if (base_stall) begin
                    pend_next = drive;
                end else begin
                    state_next = (FLUSH_CYCLES == 0) ? RUN : BUBBLE;
                    cnt_next   = BUBBLE_LOAD;
                end
            end
            default: state_next = RUN;
        endcase

        if (reset) begin
            drive       = '0;
            fetch_valid = 1'b0;
            flush_fb    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pend  <= '0;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
            cnt   <= cnt_next;
        end
    end

    // In HOLD, "not released" is exactly base_stall, so one term covers it.
    assign ifu_stall = reset | base_stall;
    assign push      = fetch_valid & ~ifu_stall;

    fetch_credit_cnt #(.FB_DEPTH(FB_DEPTH)) u_credit (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (fb_pop),
        .flush (flush_fb),
        .zero  (cred_zero),
        .full  (cred_full)
    );

    a_flush_refills: assert property (@(posedge clk) disable iff (reset)
        flush_fb |=> cred_full);

    assign next_pc_sel    = drive.sel;
    assign sb_type_addr   = (drive.sel == SB)   ? drive.addr : '0;
    assign uj_type_addr   = (drive.sel == UJ)   ? drive.addr : '0;
    assign jalr_type_addr = (drive.sel == JALR) ? drive.addr : '0;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction fetch unit (IFU).
- Each cycle it takes redirect requests from execute (JALR, taken SB branch) and decode (UJ jump), picks a winner by priority, and drives the IFU's next_pc_sel and target-address inputs.
- Holds a redirect that arrives while fetch is stalled, squashes wrong-path fetch groups, and tracks fetch-buffer credits so the IFU stalls when the buffer downstream is full or the backend stalls.

Parameters:
- ADDR_W, `INST_ADDR_WIDTH (32): instruction address width.
- FB_DEPTH, 8: fetch-buffer capacity in fetch groups (each group is FETCH_WIDTH instructions).
- FLUSH_CYCLES, 1: bubble cycles after an accepted redirect; covers IFU memory latency. Legal range 0..7.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- jalr_valid  in  1  execute resolved a JALR.
- jalr_addr  in  ADDR_W  JALR target.
- sb_taken  in  1  execute resolved a taken SB branch.
- sb_addr  in  ADDR_W  branch target.
- uj_valid  in  1  decode found a JAL.
- uj_addr  in  ADDR_W  JAL target.
- backend_stall  in  1  decode cannot accept a fetch group.
- fb_pop  in  1  fetch buffer dequeued one group this cycle.
- next_pc_sel  out  2  IFU PC mux select (fetch_pkg::pc_sel_e).
- sb_type_addr, uj_type_addr, jalr_type_addr  out  ADDR_W each  IFU target inputs.
- ifu_stall  out  1  IFU stall; the IFU ignores next_pc_sel while this is high.
- fetch_valid  out  1  the IFU output group this cycle is on-path and is pushed to the buffer.
- flush_fb  out  1  one-cycle pulse that clears the fetch buffer.

Behaviour:
- Encoding of next_pc_sel: PC_PLUS4=0, SB=1, UJ=2, JALR=3.
- Redirect priority: jalr_valid > sb_taken > uj_valid. Execute-stage redirects are older than decode-stage ones. jalr_valid and sb_taken together is illegal; the bench asserts this, and the RTL resolves it as JALR.
- Credits:
  - 4-bit counter `credits`, reset to FB_DEPTH.
  - Push = fetch_valid & ~ifu_stall.
  - credits_next = credits - push + fb_pop. Push and pop in the same cycle leave it unchanged.
  - Never exceeds FB_DEPTH; never goes below 0.
  - Set to FB_DEPTH on flush.
- Stall: ifu_stall = backend_stall | (credits==0) | (state==HOLD & ~release), where release = ~backend_stall & credits!=0.
- FSM states:
  - RUN:
    - Redirect present and ~stall_cond: accept combinationally. Drive next_pc_sel and the winning address the same cycle; the IFU loads the target at the next edge. fetch_valid=0 (the current group is wrong-path). flush_fb=1. Go to BUBBLE, or stay in RUN if FLUSH_CYCLES=0.
    - Redirect present with stall_cond: capture sel and addr into a pending register and go to HOLD. fetch_valid=0 and flush_fb=1 in the capture cycle.
    - No redirect: next_pc_sel=PC_PLUS4 and fetch_valid=~ifu_stall.
  - HOLD:
    - Drive the pending sel and addr.
    - ifu_stall stays high until release. In the release cycle ifu_stall=0, the IFU takes the pending target, and the FSM goes to BUBBLE (or RUN if FLUSH_CYCLES=0).
    - A new redirect in HOLD overwrites pending only if it has strictly higher priority than the pending one; flush_fb pulses again.
    - fetch_valid=0 throughout.
  - BUBBLE:
    - 3-bit counter loaded with FLUSH_CYCLES on entry.
    - fetch_valid=0 and next_pc_sel=PC_PLUS4. The counter decrements only when ~ifu_stall. Go to RUN when it reaches 1 and decrements.
    - A redirect in BUBBLE is handled exactly as in RUN and restarts the bubble count.
- Address outputs are driven from the winning or pending address. Non-selected address outputs are 0.
- Reset values:
  - state=RUN, credits=FB_DEPTH, pending cleared.
  - next_pc_sel=PC_PLUS4, all address outputs 0.
  - ifu_stall=1 in the reset cycle, fetch_valid=0, flush_fb=0.
- Reset mid-HOLD or mid-BUBBLE drops the pending redirect. The first cycle after reset is RUN.

Decomposition:
- fetch_pkg:
  - pc_sel_e enum (the 2-bit encoding above).
  - fctrl_state_e {RUN, HOLD, BUBBLE}.
  - redirect_t struct {sel, addr}.
  - pc_sel_prio() function.
- One natural sub-module: fetch_credit_cnt. It holds the credit counter, reports zero/full, and asserts that credits never underflow or overflow.

Test Plan:
- Reset then free-run, no stall, no redirect: next_pc_sel=0, fetch_valid=1 each cycle, and credits fall 8→0 over 8 pushes. ifu_stall=1 on the 9th cycle. One fb_pop gives exactly one more push.
- jalr_valid with jalr_addr=16 and uj_valid with uj_addr=24 in the same RUN cycle: next_pc_sel=3, jalr_type_addr=16, flush_fb=1, fetch_valid=0. Next cycle is BUBBLE with fetch_valid=0; the cycle after that is RUN with fetch_valid=1 and credits=8.
- uj_valid with uj_addr=8 while backend_stall=1: HOLD, sel=2 held for 3 stall cycles. On the cycle backend_stall drops, ifu_stall=0 with next_pc_sel=2 and uj_type_addr=8.
- In HOLD with pending UJ at 8, sb_taken with sb_addr=20 arrives: pending becomes SB at 20 and flush_fb pulses. A later uj_valid leaves pending unchanged.
- sb_taken with sb_addr=20 during BUBBLE: re-accepted with sel=1 and the bubble count restarts. Assert reset mid-HOLD: next cycle is RUN, sel=0, all addresses 0, credits=8.
- Credits at 0 with push and pop in the same cycle: credits stay 0, and ifu_stall stays 1 until a pop occurs without a push.
